// File: rtl/shift_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module      : shift_operand_stage
//  Description : ID/EX pipeline register feeding the EX-stage shifter.
//                Forwards rs1/rs2 from EX/MEM and MEM/WB, selects the shift
//                amount from rs2 or the immediate, and registers the shifter
//                operands behind a valid/ready handshake with stall and flush.
//  Revision    : 1.0  initial release
// ============================================================================
module shift_operand_stage #(
    parameter int XLEN = 32,
    parameter int SHW  = 5
) (
    input  logic            clk,
    input  logic            rst,
    // decode side
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [XLEN-1:0] in_imm,
    input  logic [4:0]      in_rs1_addr,
    input  logic [4:0]      in_rs2_addr,
    input  logic [4:0]      in_rd_addr,
    input  logic            in_use_imm,
    input  logic [1:0]      in_shiftctr,
    // forwarding sources
    input  logic            exmem_wen,
    input  logic [4:0]      exmem_rd,
    input  logic [XLEN-1:0] exmem_data,
    input  logic            memwb_wen,
    input  logic [4:0]      memwb_rd,
    input  logic [XLEN-1:0] memwb_data,
    // control
    input  logic            flush,
    // EX side
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] ALU_DA,
    output logic [SHW-1:0]  ALU_SHIFT,
    output logic [1:0]      Shiftctr,
    output logic [4:0]      out_rd_addr
);

    localparam logic [1:0] c_SHIFT_PASS = 2'b11;

    logic            r_valid;
    logic [XLEN-1:0] r_da;
    logic [SHW-1:0]  r_shift;
    logic [1:0]      r_shiftctr;
    logic [4:0]      r_rd_addr;

    logic [XLEN-1:0] w_rs1_fwd;
    logic [XLEN-1:0] w_rs2_fwd;
    logic [SHW-1:0]  w_shamt;
    logic            w_accept;
    logic            w_unused_upper;

    // Bypass selection: EX/MEM is the younger producer and wins over MEM/WB.
    // x0 is hard-wired zero in the register file, so it is never bypassed.
    function automatic logic [XLEN-1:0] bypass(
        input logic [4:0]      addr,
        input logic [XLEN-1:0] rf_data,
        input logic            ex_wen,
        input logic [4:0]      ex_rd,
        input logic [XLEN-1:0] ex_data,
        input logic            wb_wen,
        input logic [4:0]      wb_rd,
        input logic [XLEN-1:0] wb_data
    );
        logic [XLEN-1:0] sel;
        sel = rf_data;
        if (addr != 5'd0) begin
            if (ex_wen && (ex_rd == addr)) begin
                sel = ex_data;
            end else if (wb_wen && (wb_rd == addr)) begin
                sel = wb_data;
            end
        end
        return sel;
    endfunction

    // Resolve both source operands and the shift amount in the load cycle.
    always_comb begin
        w_rs1_fwd = bypass(in_rs1_addr, in_rs1_data, exmem_wen, exmem_rd,
                           exmem_data, memwb_wen, memwb_rd, memwb_data);
        w_rs2_fwd = bypass(in_rs2_addr, in_rs2_data, exmem_wen, exmem_rd,
                           exmem_data, memwb_wen, memwb_rd, memwb_data);
        // Only the low SHW bits matter; a shift by XLEN wraps to zero.
        w_shamt   = in_use_imm ? in_imm[SHW-1:0] : w_rs2_fwd[SHW-1:0];
    end

    // Upper operand bits are intentionally dropped by the shift-amount select.
    assign w_unused_upper = ^{in_imm[XLEN-1:SHW], w_rs2_fwd[XLEN-1:SHW]};

    // The register can take a new instruction when empty or being drained.
    assign in_ready = !rst && (!r_valid || out_ready);
    assign w_accept = in_valid && in_ready && !flush;

    // Pipeline register: reset > flush > load > drain; data frozen otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_da       <= '0;
            r_shift    <= '0;
            r_shiftctr <= c_SHIFT_PASS;
            r_rd_addr  <= 5'd0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid    <= 1'b1;
            r_da       <= w_rs1_fwd;
            r_shift    <= w_shamt;
            r_shiftctr <= in_shiftctr;
            r_rd_addr  <= in_rd_addr;
        end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid   = r_valid;
    assign ALU_DA      = r_da;
    assign ALU_SHIFT   = r_shift;
    assign Shiftctr    = r_shiftctr;
    assign out_rd_addr = r_rd_addr;

endmodule
`default_nettype wire

// File: tb/tb_shift_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_operand_stage
//  Description : Self-checking bench for shift_operand_stage with a one-deep
//                scoreboard model of the pipeline register.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_shift_operand_stage;

    localparam int XLEN = 32;
    localparam int SHW  = 5;

    typedef struct {
        logic [XLEN-1:0] da;
        logic [SHW-1:0]  sh;
        logic [1:0]      ctr;
        logic [4:0]      rd;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_rs1_data, in_rs2_data, in_imm;
    logic [4:0]      in_rs1_addr, in_rs2_addr, in_rd_addr;
    logic            in_use_imm;
    logic [1:0]      in_shiftctr;
    logic            exmem_wen, memwb_wen;
    logic [4:0]      exmem_rd, memwb_rd;
    logic [XLEN-1:0] exmem_data, memwb_data;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] ALU_DA;
    logic [SHW-1:0]  ALU_SHIFT;
    logic [1:0]      Shiftctr;
    logic [4:0]      out_rd_addr;

    int   checks   = 0;
    int   failures = 0;
    bit   mon_en   = 1'b0;
    bit   m_valid  = 1'b0;
    exp_t sb_q[$];

    shift_operand_stage #(.XLEN(XLEN), .SHW(SHW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
        .in_use_imm(in_use_imm), .in_shiftctr(in_shiftctr),
        .exmem_wen(exmem_wen), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
        .memwb_wen(memwb_wen), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .ALU_DA(ALU_DA), .ALU_SHIFT(ALU_SHIFT), .Shiftctr(Shiftctr),
        .out_rd_addr(out_rd_addr)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [XLEN-1:0] model_fwd(input logic [4:0] a, input logic [XLEN-1:0] rf);
        if (a == 5'd0)                          return rf;
        if (exmem_wen && exmem_rd == a)         return exmem_data;
        if (memwb_wen && memwb_rd == a)         return memwb_data;
        return rf;
    endfunction

    // Reference model: one-deep register, updated on every rising edge.
    always @(posedge clk) begin
        exp_t e;
        logic [XLEN-1:0] r2;
        bit   rdy;
        rdy = !rst && (!m_valid || out_ready);
        if (rst || flush) begin
            sb_q.delete();
        end else begin
            if (m_valid && out_ready && sb_q.size() > 0) void'(sb_q.pop_front());
            if (in_valid && rdy) begin
                r2    = model_fwd(in_rs2_addr, in_rs2_data);
                e.da  = model_fwd(in_rs1_addr, in_rs1_data);
                e.sh  = in_use_imm ? in_imm[SHW-1:0] : r2[SHW-1:0];
                e.ctr = in_shiftctr;
                e.rd  = in_rd_addr;
                sb_q.push_back(e);
            end
        end
        m_valid = (sb_q.size() != 0);
    end

    // Monitor: compare handshake and held operands each cycle, away from the edge.
    always @(negedge clk) begin
        if (mon_en) begin
            check_value("in_ready", in_ready, !rst && (!m_valid || out_ready));
            check_value("out_valid", out_valid, m_valid);
            if (m_valid && sb_q.size() > 0) begin
                check_value("sb_da",  ALU_DA,      sb_q[0].da);
                check_value("sb_sh",  ALU_SHIFT,   sb_q[0].sh);
                check_value("sb_ctr", Shiftctr,    sb_q[0].ctr);
                check_value("sb_rd",  out_rd_addr, sb_q[0].rd);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                             input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] rd,
                             input logic ui, input logic [1:0] ctr);
        in_rs1_data = d1; in_rs2_data = d2; in_imm = imm;
        in_rs1_addr = a1; in_rs2_addr = a2; in_rd_addr = rd;
        in_use_imm  = ui; in_shiftctr = ctr;
    endtask

    task automatic check_reset_values(input string tag);
        check_value({tag, "_valid"}, out_valid,   0);
        check_value({tag, "_da"},    ALU_DA,      0);
        check_value({tag, "_sh"},    ALU_SHIFT,   0);
        check_value({tag, "_ctr"},   Shiftctr,    2'b11);
        check_value({tag, "_rd"},    out_rd_addr, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        set_instr(0, 0, 0, 0, 0, 0, 1'b0, 2'b00);
        exmem_wen = 0; exmem_rd = 0; exmem_data = 0;
        memwb_wen = 0; memwb_rd = 0; memwb_data = 0;

        // 1. reset then basic load
        tick(); tick();
        mon_en = 1'b1;
        @(negedge clk);
        check_reset_values("reset");
        check_value("reset_in_ready", in_ready, 0);
        tick();
        rst = 1'b0;
        set_instr(32'h80000001, 32'd4, 0, 5'd1, 5'd2, 5'd3, 1'b0, 2'b10);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check_value("load_valid", out_valid, 1);
        check_value("load_da", ALU_DA, 32'h80000001);
        check_value("load_sh", ALU_SHIFT, 4);
        check_value("load_ctr", Shiftctr, 2'b10);
        tick();

        // 2. forwarding priority
        set_instr(32'h11111111, 32'd1, 0, 5'd5, 5'd9, 5'd4, 1'b0, 2'b00);
        exmem_wen = 1; exmem_rd = 5; exmem_data = 32'hAAAA0000;
        memwb_wen = 1; memwb_rd = 5; memwb_data = 32'h12345678;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check_value("fwd_exmem", ALU_DA, 32'hAAAA0000);
        tick();
        exmem_wen = 0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check_value("fwd_memwb", ALU_DA, 32'h12345678);
        tick();
        set_instr(32'hCAFEF00D, 32'd1, 0, 5'd0, 5'd9, 5'd4, 1'b0, 2'b01);
        exmem_wen = 1; exmem_rd = 0; memwb_rd = 0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check_value("fwd_x0", ALU_DA, 32'hCAFEF00D);
        tick();
        exmem_wen = 0; memwb_wen = 0;

        // 3. shift amount select and wrap
        set_instr(32'h1, 32'd7, 32'h0000043F, 5'd1, 5'd2, 5'd3, 1'b1, 2'b00);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check_value("imm_sh", ALU_SHIFT, 31);
        tick();
        set_instr(32'h1, 32'd5, 32'h1F, 5'd1, 5'd6, 5'd3, 1'b0, 2'b01);
        memwb_wen = 1; memwb_rd = 6; memwb_data = 32'd32;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        memwb_wen = 0;
        @(negedge clk);
        check_value("wrap_sh", ALU_SHIFT, 0);
        tick();

        // 4. stall holds A, then B follows with no loss or duplication
        out_ready = 1'b0;
        set_instr(32'hA0A0A0A0, 32'd3, 0, 5'd1, 5'd2, 5'd7, 1'b0, 2'b00);
        in_valid = 1'b1;
        tick();
        set_instr(32'hB0B0B0B0, 32'd9, 0, 5'd1, 5'd2, 5'd8, 1'b0, 2'b01);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_value("stall_in_ready", in_ready, 0);
            check_value("stall_da", ALU_DA, 32'hA0A0A0A0);
            check_value("stall_rd", out_rd_addr, 7);
            tick();
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check_value("after_stall_da", ALU_DA, 32'hB0B0B0B0);
        check_value("after_stall_rd", out_rd_addr, 8);
        tick();
        @(negedge clk);
        check_value("after_stall_drain", out_valid, 0);

        // 5. flush kills held and incoming instructions
        tick();
        out_ready = 1'b0;
        set_instr(32'hC0C0C0C0, 32'd2, 0, 5'd1, 5'd2, 5'd9, 1'b0, 2'b00);
        in_valid = 1'b1;
        tick();
        set_instr(32'hD0D0D0D0, 32'd2, 0, 5'd1, 5'd2, 5'd10, 1'b0, 2'b00);
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check_value("flush_valid", out_valid, 0);
        tick();
        @(negedge clk);
        check_value("flush_dropped", out_valid, 0);
        tick();
        set_instr(32'hE0E0E0E0, 32'd2, 0, 5'd1, 5'd2, 5'd11, 1'b0, 2'b01);
        in_valid = 1'b1;
        tick();
        rst = 1'b1; flush = 1'b1;
        tick();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check_reset_values("flush_rst");
        tick();

        // 6. eight back-to-back instructions, no bubbles
        for (int i = 0; i < 8; i++) begin
            set_instr(32'h100 + i, i, 0, 5'd1, 5'd2, 5'(i + 1), 1'b0, 2'(i));
            in_valid = 1'b1;
            if (i > 0) begin
                @(negedge clk);
                check_value("stream_valid", out_valid, 1);
                check_value("stream_da", ALU_DA, 32'h100 + i - 1);
            end
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        check_value("stream_valid", out_valid, 1);
        check_value("stream_da", ALU_DA, 32'h107);
        tick();
        @(negedge clk);
        check_value("stream_end", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shift_operand_stage.md
Name: shift_operand_stage

Overview:
- ID/EX pipeline register that feeds the EX-stage shifter.
- Accepts decoded shift instructions from decode and resolves rs1/rs2 data hazards by forwarding from EX/MEM and MEM/WB.
- Selects the shift amount from rs2 or the immediate.
- Registers ALU_DA / ALU_SHIFT / Shiftctr with a valid/ready handshake, stall hold and flush.

Parameters:
- XLEN, 32, datapath width of operands and forwarded results.
- SHW, 5, shift-amount width; equals log2(XLEN).

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  decode presents a valid instruction.
- in_ready  out  1  stage can accept this cycle.
- in_rs1_data  in  XLEN  register-file read of rs1.
- in_rs2_data  in  XLEN  register-file read of rs2.
- in_imm  in  XLEN  decoded immediate.
- in_rs1_addr  in  5  rs1 index.
- in_rs2_addr  in  5  rs2 index.
- in_rd_addr  in  5  destination index.
- in_use_imm  in  1  1 = shift amount from in_imm[SHW-1:0]; 0 = from forwarded rs2.
- in_shiftctr  in  2  shift op: 00 SLL, 01 SRL, 10 SRA, 11 pass.
- exmem_wen  in  1  EX/MEM write-enable.
- exmem_rd  in  5  EX/MEM destination index.
- exmem_data  in  XLEN  EX/MEM result.
- memwb_wen  in  1  MEM/WB write-enable.
- memwb_rd  in  5  MEM/WB destination index.
- memwb_data  in  XLEN  MEM/WB result.
- flush  in  1  kill the held and incoming instruction (branch redirect).
- out_valid  out  1  registered outputs hold a valid instruction.
- out_ready  in  1  EX can consume this cycle.
- ALU_DA  out  XLEN  registered shifter data operand.
- ALU_SHIFT  out  SHW  registered shift amount.
- Shiftctr  out  2  registered shift op.
- out_rd_addr  out  5  registered destination index.

Behaviour:
- Reset (rst=1 at a rising edge): out_valid=0, ALU_DA=0, ALU_SHIFT=0, Shiftctr=2'b11, out_rd_addr=0. Reset takes priority over flush and load; a held instruction is discarded.
- in_ready = !out_valid || out_ready (combinational). It is forced to 0 while rst=1.
- Load: when in_valid && in_ready && !flush, the next edge captures the operands and sets out_valid=1. Latency is 1 cycle from accept to out_valid.
- Drain: out_valid && out_ready && !(in_valid && in_ready) -> next out_valid=0. Data registers may keep stale values.
- Back-to-back: simultaneous accept and consume gives the new instruction with no bubble. Full throughput is one instruction per cycle.
- Stall: while out_valid && !out_ready, ALU_DA / ALU_SHIFT / Shiftctr / out_rd_addr stay bit-stable and in_ready=0.
- Flush: next out_valid=0 and the incoming instruction is not captured, regardless of in_valid and out_ready. Flush is ignored during rst.
- Forwarding is evaluated combinationally in the load cycle, independently for rs1 and rs2:
  - First priority: exmem_wen && exmem_rd==addr && addr!=0 -> exmem_data.
  - Otherwise: memwb_wen && memwb_rd==addr && addr!=0 -> memwb_data.
  - Otherwise: the register-file value.
  - Index 0 is never forwarded; it always passes in_rsX_data.
- Operand mapping:
  - ALU_DA <= forwarded rs1.
  - ALU_SHIFT <= in_use_imm ? in_imm[SHW-1:0] : forwarded_rs2[SHW-1:0]. Upper bits are ignored, so a shift by 32 wraps to 0.
  - Shiftctr <= in_shiftctr.
  - out_rd_addr <= in_rd_addr.
- A held (stalled) instruction is not re-forwarded: operands are frozen at capture. Producers must not retire a needed value before capture; hazard detection upstream guarantees this.
- No combinational path from out_ready to any registered output. The only path from out_ready is to in_ready.

Test Plan:
1. Reset and basic load:
   - rst 2 cycles -> out_valid=0, Shiftctr=11.
   - Then in_valid with rs1_data=0x80000001, rs2_data=4, use_imm=0, shiftctr=10 -> next cycle out_valid=1, ALU_DA=0x80000001, ALU_SHIFT=4, Shiftctr=10.
2. Forwarding priority:
   - in_rs1_addr=5, exmem_wen=1 with exmem_rd=5, exmem_data=0xAAAA0000; memwb_wen=1 with memwb_rd=5, memwb_data=0x12345678 -> ALU_DA=0xAAAA0000.
   - Drop exmem_wen -> ALU_DA=0x12345678.
   - Set rs1_addr=0 with both matching rd=0 -> ALU_DA=in_rs1_data.
3. Shift-amount select and wrap:
   - use_imm=1, imm=0x0000043F -> ALU_SHIFT=31.
   - use_imm=0, forwarded rs2=32 -> ALU_SHIFT=0.
4. Stall:
   - Load instr A; hold out_ready=0 for 3 cycles while in_valid=1 with instr B -> in_ready=0 and outputs equal A all 3 cycles.
   - Raise out_ready -> B appears the following cycle, with no loss or duplication.
5. Flush:
   - out_valid=1 and out_ready=0, assert flush with in_valid=1 -> next cycle out_valid=0 and the incoming instruction is dropped.
   - Flush during rst -> reset values.
6. Throughput: stream 8 instructions with out_ready=1 -> 8 consecutive out_valid cycles, in order, with no bubbles.
